// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron training controller.
// Holds the 16-bit training-sample layout
//   {desired[15], in3[14:8], in2[7:4], in1[3:0]}
// and the controller FSM state encoding.
package perceptron_pkg;

  localparam int SAMPLE_W = 16;
  localparam int IN1_W    = 4;
  localparam int IN2_W    = 4;
  localparam int IN3_W    = 7;
  localparam int IN1_LSB  = 0;
  localparam int IN2_LSB  = 4;
  localparam int IN3_LSB  = 8;
  localparam int DES_BIT  = 15;

  typedef struct packed {
    logic             desired;
    logic [IN3_W-1:0] in3;
    logic [IN2_W-1:0] in2;
    logic [IN1_W-1:0] in1;
  } sample_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_APPLY,
    S_EVAL,
    S_EPOCH_END,
    S_DONE
  } state_e;

  function automatic sample_t pack_sample(logic des, logic [IN3_W-1:0] i3,
                                          logic [IN2_W-1:0] i2, logic [IN1_W-1:0] i1);
    return sample_t'({des, i3, i2, i1});
  endfunction

endpackage

// File: rtl/perceptron_sample_mem.sv
// Training-set storage: DEPTH x 16-bit samples, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  packed sample to store
//   raddr_i  read index
//   rdata_o  packed sample at raddr_i (combinational)
module perceptron_sample_mem
  import perceptron_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Epoch-based training sequencer for a 3-input perceptron. Streams the
// stored training set into the perceptron two cycles per sample, counts
// misclassifications per epoch, and stops on a zero-error epoch or after
// MAX_EPOCHS.
//   clk_i / reset_i     clock, async active-high reset
//   cfg_we_i/addr/data  training-set write (only while idle)
//   num_samples_i       active sample count, captured on start
//   start_i             begin training from fresh perceptron weights
//   busy_o / done_o     run in progress / 1-cycle end-of-run pulse
//   converged_o         last epoch had zero errors (valid after done)
//   epoch_count_o       epochs completed
//   err_count_o         errors in the most recently completed epoch
//   p_rst_n_o           registered active-low perceptron reset
//   p_in1/2/3_o         perceptron inputs
//   p_desired_o         perceptron desired output
//   p_out_i             perceptron registered output
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int MAX_EPOCHS = 64,
  parameter int EPOCH_W    = 7
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cfg_we_i,
  input  logic [ADDR_W-1:0]   cfg_addr_i,
  input  logic [SAMPLE_W-1:0] cfg_data_i,
  input  logic [ADDR_W:0]     num_samples_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                converged_o,
  output logic [EPOCH_W-1:0]  epoch_count_o,
  output logic [ADDR_W:0]     err_count_o,
  output logic                p_rst_n_o,
  output logic [IN1_W-1:0]    p_in1_o,
  output logic [IN2_W-1:0]    p_in2_o,
  output logic [IN3_W-1:0]    p_in3_o,
  output logic                p_desired_o,
  input  logic                p_out_i
);

  localparam logic [ADDR_W:0]    ERR_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [EPOCH_W-1:0] EP_MAX  = EPOCH_W'(MAX_EPOCHS);
  localparam logic [EPOCH_W-1:0] EP_ONE  = EPOCH_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [ADDR_W:0]     err_run_q, err_run_d;
  logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic                conv_q, conv_d;
  logic                prstn_q, prstn_d;
  sample_t             smp_q, smp_d;
  logic [SAMPLE_W-1:0] rd_data;
  logic                last_smp, mis, epoch_last;

  // Read address follows the next index so the sample lands in smp_q on
  // the same edge that enters APPLY.
  perceptron_sample_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk_i   (clk_i),
    .we_i    (cfg_we_i && (state_q == S_IDLE)),
    .waddr_i (cfg_addr_i),
    .wdata_i (cfg_data_i),
    .raddr_i (idx_d),
    .rdata_o (rd_data)
  );

  assign last_smp   = ({1'b0, idx_q} == (num_q - CNT_ONE));
  assign mis        = (p_out_i != smp_q.desired);
  assign epoch_last = ((epoch_q + EP_ONE) == EP_MAX);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_i) state_d = (num_samples_i == '0) ? S_DONE : S_CLEAR;
      S_CLEAR:     state_d = S_APPLY;
      S_APPLY:     state_d = S_EVAL;
      S_EVAL:      state_d = last_smp ? S_EPOCH_END : S_APPLY;
      S_EPOCH_END: state_d = ((err_run_q == '0) || epoch_last) ? S_DONE : S_APPLY;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    idx_d     = idx_q;
    num_d     = num_q;
    err_run_d = err_run_q;
    err_cnt_d = err_cnt_q;
    epoch_d   = epoch_q;
    conv_d    = conv_q;
    prstn_d   = (state_d != S_CLEAR);
    smp_d     = smp_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        num_d  = num_samples_i;
        conv_d = 1'b0;
        if (num_samples_i == '0) begin
          conv_d    = 1'b1;
          epoch_d   = '0;
          err_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        idx_d     = '0;
        epoch_d   = '0;
        err_run_d = '0;
        err_cnt_d = '0;
      end
      S_EVAL: begin
        if (mis && (err_run_q != ERR_MAX)) err_run_d = err_run_q + CNT_ONE;
        if (!last_smp) idx_d = idx_q + 1'b1;
      end
      S_EPOCH_END: begin
        epoch_d   = epoch_q + EP_ONE;
        err_cnt_d = err_run_q;
        err_run_d = '0;
        idx_d     = '0;
        if (err_run_q == '0) conv_d = 1'b1;
      end
      default: ;
    endcase
    if (state_d == S_APPLY) smp_d = sample_t'(rd_data);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q     <= '0;
      num_q     <= '0;
      err_run_q <= '0;
      err_cnt_q <= '0;
      epoch_q   <= '0;
      conv_q    <= 1'b0;
      prstn_q   <= 1'b0;
      smp_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      num_q     <= num_d;
      err_run_q <= err_run_d;
      err_cnt_q <= err_cnt_d;
      epoch_q   <= epoch_d;
      conv_q    <= conv_d;
      prstn_q   <= prstn_d;
      smp_q     <= smp_d;
    end
  end

  // Outputs. Outside EVAL the desired bit mirrors p_out so the perceptron
  // sees no error and leaves its weights alone.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DONE);
    p_desired_o = (state_q == S_EVAL) ? smp_q.desired : p_out_i;
  end

  assign converged_o   = conv_q;
  assign epoch_count_o = epoch_q;
  assign err_count_o   = err_cnt_q;
  assign p_rst_n_o     = prstn_q;
  assign p_in1_o       = smp_q.in1;
  assign p_in2_o       = smp_q.in2;
  assign p_in3_o       = smp_q.in3;

endmodule
